// File: rtl/hilo_unit.sv
// HI/LO register file behind the iterative multiplier: tracks an issued multiply,
// captures the product, serves bypassed MFHI/MFLO reads and raises the decode interlock.
module hilo_unit #(
  parameter int WIDTH   = 32,
  parameter int MAX_LAT = 70
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               multE,
  input  logic               flushE,
  input  logic               mult_stall,
  input  logic [2*WIDTH-1:0] s,
  input  logic               mthiW,
  input  logic               mtloW,
  input  logic [WIDTH-1:0]   wdataW,
  input  logic               mfhiD,
  input  logic               mfloD,
  output logic [WIDTH-1:0]   hiD,
  output logic [WIDTH-1:0]   loD,
  output logic               hilo_stall,
  output logic               busy,
  output logic               wd_err
);

  localparam int CW = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUED,
    BUSY
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             ovh, ovl;
  logic             iss_low;
  logic [CW-1:0]    cnt;
  logic             cap, wd_fire, start;
  logic             pend_hi, pend_lo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cap      = 1'b0;
    wd_fire  = 1'b0;
    start    = 1'b0;
    case (state)
      IDLE: begin
        if (multE && !flushE) begin
          state_nx = ISSUED;
          start    = 1'b1;
        end
      end
      ISSUED: begin
        // A multiplier that never raises its busy flag is taken as done
        // after two consecutive low cycles.
        if (flushE)          state_nx = IDLE;
        else if (mult_stall) state_nx = BUSY;
        else if (iss_low) begin
          cap      = 1'b1;
          state_nx = IDLE;
        end
      end
      BUSY: begin
        if (flushE) state_nx = IDLE;
        else if (!mult_stall) begin
          cap      = 1'b1;
          state_nx = IDLE;
        end else if (cnt == CW'(MAX_LAT - 1)) begin
          wd_fire  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_r    <= '0;
      lo_r    <= '0;
      ovh     <= 1'b0;
      ovl     <= 1'b0;
      iss_low <= 1'b0;
      cnt     <= '0;
      wd_err  <= 1'b0;
    end else begin
      if (mthiW)             hi_r <= wdataW;
      else if (cap && !ovh)  hi_r <= s[2*WIDTH-1:WIDTH];
      if (mtloW)             lo_r <= wdataW;
      else if (cap && !ovl)  lo_r <= s[WIDTH-1:0];

      // Younger W-stage writes during an outstanding multiply shadow its product.
      if (start)                         ovh <= 1'b0;
      else if (mthiW && state != IDLE)   ovh <= 1'b1;
      if (start)                         ovl <= 1'b0;
      else if (mtloW && state != IDLE)   ovl <= 1'b1;

      if (start)                              iss_low <= 1'b0;
      else if (state == ISSUED && !mult_stall) iss_low <= 1'b1;

      if (start)              cnt <= '0;
      else if (state == BUSY) cnt <= cnt + 1'b1;

      if (wd_fire) wd_err <= 1'b1;
    end
  end

  always_comb begin
    hiD = hi_r;
    loD = lo_r;
    if (mthiW)            hiD = wdataW;
    else if (cap && !ovh) hiD = s[2*WIDTH-1:WIDTH];
    if (mtloW)            loD = wdataW;
    else if (cap && !ovl) loD = s[WIDTH-1:0];

    pend_hi    = (state != IDLE) && !ovh && !cap;
    pend_lo    = (state != IDLE) && !ovl && !cap;
    hilo_stall = (mfhiD && pend_hi) || (mfloD && pend_lo) || ((mfhiD || mfloD) && start);
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- HI/LO register file sitting directly downstream of the iterative multiplier.
- Tracks each multiply issued in E and waits for the multiplier's busy/stall signal to drop.
- Captures the 64-bit product into HI/LO, and serves MFHI/MFLO reads in D.
- Handles MTHI/MTLO writes from W and generates the decode interlock stall while a product is outstanding.

Parameters:
- WIDTH, 32, width of each of HI and LO; the product is 2*WIDTH.
- MAX_LAT, 70, watchdog limit in cycles spent in BUSY before the multiply is abandoned.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- multE  in  1  multiply issued in E this cycle.
- flushE  in  1  squash the multiply being issued or pending.
- mult_stall  in  1  multiplier busy flag.
- s  in  2*WIDTH  multiplier product; valid in the cycle mult_stall falls.
- mthiW  in  1  write HI from W.
- mtloW  in  1  write LO from W.
- wdataW  in  WIDTH  write data for mthiW/mtloW.
- mfhiD  in  1  D-stage read of HI.
- mfloD  in  1  D-stage read of LO.
- hiD  out  WIDTH  HI read value, bypassed.
- loD  out  WIDTH  LO read value, bypassed.
- hilo_stall  out  1  stall D; an MF read must wait.
- busy  out  1  state != IDLE.
- wd_err  out  1  sticky watchdog error.

Behaviour:
- Reset (async) values:
  - HI = 0, LO = 0, state = IDLE.
  - Override flags ovh = ovl = 0.
  - Counter = 0, wd_err = 0.
  - Outputs: hiD = loD = 0, hilo_stall = 0, busy = 0.
- Reset mid-multiply: return to IDLE with no capture; a later mult_stall fall is ignored.
- State machine:
  - IDLE:
    - multE & !flushE -> ISSUED; clear ovh/ovl and the counter.
  - ISSUED:
    - Waiting for the multiplier to assert mult_stall.
    - mult_stall=1 -> BUSY.
    - flushE -> IDLE.
    - If mult_stall stays 0 for 2 cycles, treat the multiply as done: capture s, -> IDLE.
  - BUSY:
    - Counter increments every cycle.
    - mult_stall=0 -> capture at that clock edge and go to IDLE: HI <= s[2*WIDTH-1:WIDTH] unless ovh; LO <= s[WIDTH-1:0] unless ovl.
    - flushE -> IDLE, no capture.
    - Counter reaches MAX_LAT -> IDLE, wd_err <= 1, no capture.
  - multE while not IDLE is ignored; the multiplier stall already holds issue.
- MTHI/MTLO:
  - Written at the clock edge in any state.
  - While ISSUED/BUSY, mthiW sets ovh and mtloW sets ovl. The later product capture then skips that half, because the W-stage write is younger in program order.
  - If a capture and an MT write hit the same half on the same edge, the MT write wins.
- Reads (combinational):
  - hiD priority: mthiW ? wdataW : (capture this cycle & !ovh) ? s-high : HI.
  - loD: same structure using mtloW, ovl and s-low.
- Stall:
  - hilo_stall = (mfhiD & pend_hi) | (mfloD & pend_lo).
  - pend_x = (state is ISSUED or BUSY) & !ovx & !capture-this-cycle.
  - Also stall an MF read in the same cycle as multE & !flushE, since the multiply is older.
- Widths: the product splits exactly at bit WIDTH. No sign handling here; signedness is resolved by the multiplier.
- wd_err clears only on reset.

Test Plan:
- Signed multiply: multE with product -77*999; drive mult_stall high 64 cycles, then low with s=64'hFFFFFFFF_FFFED385.
  - Expect HI=32'hFFFFFFFF, LO=32'hFFFED385.
  - busy high throughout and low the next cycle.
- Unsigned multiply: s=64'hFFFFFFFE_00000001.
  - mfhiD held during BUSY -> hilo_stall=1 every cycle.
  - In the fall cycle: hilo_stall=0, hiD=32'hFFFFFFFE (bypass).
  - LO=1 afterwards.
- MT override: during BUSY pulse mtloW with wdataW=32'h1234_5678, then product 64'hAAAA_AAAA_BBBB_BBBB.
  - Expect HI=32'hAAAAAAAA, LO=32'h12345678.
  - mfloD does not stall after the mtlo; mfhiD does.
- Flush: multE then flushE in BUSY at cycle 10; the later mult_stall fall with s=64'h1 must not change HI/LO (previous 32'hAAAAAAAA/32'h12345678 retained).
- Watchdog: hold mult_stall=1 for MAX_LAT+5 cycles.
  - State returns to IDLE after MAX_LAT cycles, wd_err=1, HI/LO unchanged, hilo_stall=0.
- Reset mid-BUSY: assert reset asynchronously (between edges) at cycle 20.
  - Immediately HI=LO=0, busy=0, wd_err=0.
  - The subsequent mult_stall fall produces no capture.
